bin_switch_ctrl: RTL and testbench



---
 rtl/bin_switch_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_bin_switch_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_switch_ctrl.sv
// ============================================================================
// Module      : bin_switch_ctrl
// Description : Bin manager sequencer. It writes back the resident bin, loads
//               the requested bin, owns the BRAM mux select, and times out
//               into a sticky error state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_switch_ctrl #(
    parameter int WIDTH_BIN_ID   = 10,
    parameter int NUM_BINS       = 64,
    parameter int WIDTH_TIMEOUT  = 10,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    switch_req_i,
    input  logic [WIDTH_BIN_ID-1:0] req_bin_num_i,
    input  logic                    flush_req_i,
    output logic                    ack_o,
    output logic                    req_err_o,
    output logic                    start_update_o,
    output logic [WIDTH_BIN_ID-1:0] cur_bin_num_o,
    input  logic                    done_update_i,
    output logic                    start_load_o,
    output logic [WIDTH_BIN_ID-1:0] load_bin_num_o,
    input  logic                    done_load_i,
    output logic [1:0]              ram_sel_o,
    output logic                    resident_valid_o,
    output logic                    busy_o,
    output logic                    error_o,
    input  logic                    clear_err_i
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_UPD_START = 3'd1,
        S_UPD_WAIT  = 3'd2,
        S_LD_START  = 3'd3,
        S_LD_WAIT   = 3'd4,
        S_ACK       = 3'd5,
        S_ERR       = 3'd6
    } state_t;

    localparam logic [WIDTH_BIN_ID:0]    c_num_bins   = (WIDTH_BIN_ID+1)'(NUM_BINS);
    localparam logic [WIDTH_TIMEOUT-1:0] c_to_last    = WIDTH_TIMEOUT'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]               c_sel_none   = 2'd0;
    localparam logic [1:0]               c_sel_update = 2'd1;
    localparam logic [1:0]               c_sel_loader = 2'd2;

    state_t                    r_state, w_state_nxt;
    logic [WIDTH_TIMEOUT-1:0]  r_cnt, w_cnt_nxt;
    logic [WIDTH_BIN_ID-1:0]   r_cur_bin, w_cur_bin_nxt;
    logic [WIDTH_BIN_ID-1:0]   r_load_bin, w_load_bin_nxt;
    logic                      r_resident, w_resident_nxt;
    logic                      r_is_flush, w_is_flush_nxt;
    logic                      w_req_err_nxt;
    logic                      w_out_of_range;

    logic                      r_ack, r_req_err, r_start_update, r_start_load;
    logic                      r_busy, r_error;
    logic [1:0]                r_ram_sel;

    assign w_out_of_range = ({1'b0, req_bin_num_i} >= c_num_bins);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_cur_bin_nxt  = r_cur_bin;
        w_load_bin_nxt = r_load_bin;
        w_resident_nxt = r_resident;
        w_is_flush_nxt = r_is_flush;
        w_req_err_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (flush_req_i) begin
                    w_is_flush_nxt = 1'b1;
                    w_state_nxt    = r_resident ? S_UPD_START : S_ACK;
                end else if (switch_req_i) begin
                    w_is_flush_nxt = 1'b0;
                    if (w_out_of_range) begin
                        w_req_err_nxt = 1'b1;
                        w_state_nxt   = S_ACK;
                    end else if (r_resident && (req_bin_num_i == r_cur_bin)) begin
                        w_state_nxt = S_ACK;
                    end else begin
                        w_load_bin_nxt = req_bin_num_i;
                        w_state_nxt    = r_resident ? S_UPD_START : S_LD_START;
                    end
                end
            end
            S_UPD_START: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_UPD_WAIT;
            end
            S_UPD_WAIT: begin
                if (done_update_i) begin
                    w_state_nxt = r_is_flush ? S_ACK : S_LD_START;
                end else if (r_cnt == c_to_last) begin
                    w_resident_nxt = 1'b0;
                    w_state_nxt    = S_ERR;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_LD_START: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_LD_WAIT;
            end
            S_LD_WAIT: begin
                if (done_load_i) begin
                    w_cur_bin_nxt  = r_load_bin;
                    w_resident_nxt = 1'b1;
                    w_state_nxt    = S_ACK;
                end else if (r_cnt == c_to_last) begin
                    w_resident_nxt = 1'b0;
                    w_state_nxt    = S_ERR;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_ACK: begin
                w_state_nxt = S_IDLE;
            end
            S_ERR: begin
                if (clear_err_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_cur_bin  <= '0;
            r_load_bin <= '0;
            r_resident <= 1'b0;
            r_is_flush <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cur_bin  <= w_cur_bin_nxt;
            r_load_bin <= w_load_bin_nxt;
            r_resident <= w_resident_nxt;
            r_is_flush <= w_is_flush_nxt;
        end
    end

    // Strobes are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack          <= 1'b0;
            r_req_err      <= 1'b0;
            r_start_update <= 1'b0;
            r_start_load   <= 1'b0;
            r_busy         <= 1'b0;
            r_error        <= 1'b0;
            r_ram_sel      <= c_sel_none;
        end else begin
            r_ack          <= (w_state_nxt == S_ACK);
            r_req_err      <= w_req_err_nxt;
            r_start_update <= (w_state_nxt == S_UPD_START);
            r_start_load   <= (w_state_nxt == S_LD_START);
            r_busy         <= (w_state_nxt != S_IDLE);
            r_error        <= (w_state_nxt == S_ERR);
            case (w_state_nxt)
                S_UPD_WAIT:            r_ram_sel <= c_sel_update;
                S_LD_START, S_LD_WAIT: r_ram_sel <= c_sel_loader;
                default:               r_ram_sel <= c_sel_none;
            endcase
        end
    end

    assign ack_o            = r_ack;
    assign req_err_o        = r_req_err;
    assign start_update_o   = r_start_update;
    assign start_load_o     = r_start_load;
    assign cur_bin_num_o    = r_cur_bin;
    assign load_bin_num_o   = r_load_bin;
    assign ram_sel_o        = r_ram_sel;
    assign resident_valid_o = r_resident;
    assign busy_o           = r_busy;
    assign error_o          = r_error;

endmodule

`default_nettype wire

// File: tb/tb_bin_switch_ctrl.sv
// ============================================================================
// Module      : tb_bin_switch_ctrl
// Description : Directed self-checking bench for bin_switch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_switch_ctrl;

    localparam int WB = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          switch_req_i = 1'b0;
    logic [WB-1:0] req_bin_num_i = '0;
    logic          flush_req_i = 1'b0;
    logic          ack_o, req_err_o, start_update_o, start_load_o;
    logic [WB-1:0] cur_bin_num_o, load_bin_num_o;
    logic          done_update_i = 1'b0;
    logic          done_load_i = 1'b0;
    logic [1:0]    ram_sel_o;
    logic          resident_valid_o, busy_o, error_o;
    logic          clear_err_i = 1'b0;

    int checks = 0;
    int errors = 0;

    bin_switch_ctrl #(
        .WIDTH_BIN_ID  (WB),
        .NUM_BINS      (64),
        .WIDTH_TIMEOUT (10),
        .TIMEOUT_CYCLES(20)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .switch_req_i    (switch_req_i),
        .req_bin_num_i   (req_bin_num_i),
        .flush_req_i     (flush_req_i),
        .ack_o           (ack_o),
        .req_err_o       (req_err_o),
        .start_update_o  (start_update_o),
        .cur_bin_num_o   (cur_bin_num_o),
        .done_update_i   (done_update_i),
        .start_load_o    (start_load_o),
        .load_bin_num_o  (load_bin_num_o),
        .done_load_i     (done_load_i),
        .ram_sel_o       (ram_sel_o),
        .resident_valid_o(resident_valid_o),
        .busy_o          (busy_o),
        .error_o         (error_o),
        .clear_err_i     (clear_err_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"},   32'(ack_o), 32'd0);
        chk({tag, "_rerr"},  32'(req_err_o), 32'd0);
        chk({tag, "_supd"},  32'(start_update_o), 32'd0);
        chk({tag, "_sld"},   32'(start_load_o), 32'd0);
        chk({tag, "_cur"},   32'(cur_bin_num_o), 32'd0);
        chk({tag, "_ldbin"}, 32'(load_bin_num_o), 32'd0);
        chk({tag, "_sel"},   32'(ram_sel_o), 32'd0);
        chk({tag, "_res"},   32'(resident_valid_o), 32'd0);
        chk({tag, "_busy"},  32'(busy_o), 32'd0);
        chk({tag, "_err"},   32'(error_o), 32'd0);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Empty flush: ack at cycle 1, no update
        flush_req_i = 1'b1;
        tick();
        chk("eflush_ack", 32'(ack_o), 32'd1);
        chk("eflush_supd", 32'(start_update_o), 32'd0);
        flush_req_i = 1'b0;
        tick();

        // First load of bin 3
        switch_req_i = 1'b1; req_bin_num_i = 10'd3;
        tick();
        chk("fl_c1_sld", 32'(start_load_o), 32'd1);
        chk("fl_c1_sel", 32'(ram_sel_o), 32'd2);
        chk("fl_c1_ldbin", 32'(load_bin_num_o), 32'd3);
        chk("fl_c1_supd", 32'(start_update_o), 32'd0);
        tick();
        chk("fl_c2_sel", 32'(ram_sel_o), 32'd2);
        chk("fl_c2_ack", 32'(ack_o), 32'd0);
        chk("fl_c2_supd", 32'(start_update_o), 32'd0);
        done_load_i = 1'b1;
        tick();
        done_load_i = 1'b0;
        chk("fl_c3_ack", 32'(ack_o), 32'd1);
        chk("fl_c3_cur", 32'(cur_bin_num_o), 32'd3);
        chk("fl_c3_res", 32'(resident_valid_o), 32'd1);
        chk("fl_c3_supd", 32'(start_update_o), 32'd0);
        chk("fl_c3_sel", 32'(ram_sel_o), 32'd0);
        switch_req_i = 1'b0;
        tick();
        chk("fl_idle_ack", 32'(ack_o), 32'd0);
        chk("fl_idle_busy", 32'(busy_o), 32'd0);

        // Switch 3 -> 7 with immediate dones
        switch_req_i = 1'b1; req_bin_num_i = 10'd7;
        tick();
        chk("sw_c1_supd", 32'(start_update_o), 32'd1);
        chk("sw_c1_cur", 32'(cur_bin_num_o), 32'd3);
        chk("sw_c1_busy", 32'(busy_o), 32'd1);
        tick();
        chk("sw_c2_sel", 32'(ram_sel_o), 32'd1);
        chk("sw_c2_supd", 32'(start_update_o), 32'd0);
        done_update_i = 1'b1;
        tick();
        done_update_i = 1'b0;
        chk("sw_c3_sld", 32'(start_load_o), 32'd1);
        chk("sw_c3_ldbin", 32'(load_bin_num_o), 32'd7);
        chk("sw_c3_sel", 32'(ram_sel_o), 32'd2);
        tick();
        chk("sw_c4_sel", 32'(ram_sel_o), 32'd2);
        chk("sw_c4_ack", 32'(ack_o), 32'd0);
        done_load_i = 1'b1;
        tick();
        done_load_i = 1'b0;
        chk("sw_c5_ack", 32'(ack_o), 32'd1);
        chk("sw_c5_cur", 32'(cur_bin_num_o), 32'd7);
        switch_req_i = 1'b0;
        tick();

        // Same-bin switch
        switch_req_i = 1'b1; req_bin_num_i = 10'd7;
        tick();
        chk("same_ack", 32'(ack_o), 32'd1);
        chk("same_supd", 32'(start_update_o), 32'd0);
        chk("same_sld", 32'(start_load_o), 32'd0);
        chk("same_rerr", 32'(req_err_o), 32'd0);
        switch_req_i = 1'b0;
        tick();

        // Out-of-range bin 64
        switch_req_i = 1'b1; req_bin_num_i = 10'd64;
        tick();
        chk("oor_ack", 32'(ack_o), 32'd1);
        chk("oor_rerr", 32'(req_err_o), 32'd1);
        chk("oor_cur", 32'(cur_bin_num_o), 32'd7);
        chk("oor_ldbin", 32'(load_bin_num_o), 32'd7);
        chk("oor_res", 32'(resident_valid_o), 32'd1);
        switch_req_i = 1'b0;
        tick();
        chk("oor_rerr_pulse", 32'(req_err_o), 32'd0);

        // Flush has priority over a simultaneous switch
        flush_req_i = 1'b1; switch_req_i = 1'b1; req_bin_num_i = 10'd5;
        tick();
        chk("fs_c1_supd", 32'(start_update_o), 32'd1);
        tick();
        chk("fs_c2_sel", 32'(ram_sel_o), 32'd1);
        done_update_i = 1'b1;
        tick();
        done_update_i = 1'b0;
        chk("fs_c3_ack", 32'(ack_o), 32'd1);
        chk("fs_c3_sld", 32'(start_load_o), 32'd0);
        chk("fs_c3_cur", 32'(cur_bin_num_o), 32'd7);
        chk("fs_c3_res", 32'(resident_valid_o), 32'd1);
        chk("fs_c3_ldbin", 32'(load_bin_num_o), 32'd7);
        flush_req_i = 1'b0; switch_req_i = 1'b0;
        tick();

        // Timeout in UPD_WAIT (20 cycles)
        switch_req_i = 1'b1; req_bin_num_i = 10'd9;
        tick();
        tick();
        chk("to_entry_sel", 32'(ram_sel_o), 32'd1);
        for (int i = 0; i < 19; i++) tick();
        chk("to_19_err", 32'(error_o), 32'd0);
        chk("to_19_sel", 32'(ram_sel_o), 32'd1);
        tick();
        chk("to_20_err", 32'(error_o), 32'd1);
        chk("to_20_res", 32'(resident_valid_o), 32'd0);
        chk("to_20_sel", 32'(ram_sel_o), 32'd0);
        chk("to_20_ack", 32'(ack_o), 32'd0);
        tick();
        tick();
        chk("err_hold_err", 32'(error_o), 32'd1);
        chk("err_hold_supd", 32'(start_update_o), 32'd0);
        chk("err_hold_sld", 32'(start_load_o), 32'd0);
        chk("err_hold_ack", 32'(ack_o), 32'd0);
        switch_req_i = 1'b0; clear_err_i = 1'b1;
        tick();
        clear_err_i = 1'b0;
        chk("clr_err", 32'(error_o), 32'd0);
        chk("clr_busy", 32'(busy_o), 32'd0);

        // Load with done coincident with start pulse, then reset in LD_WAIT
        switch_req_i = 1'b1; req_bin_num_i = 10'd2; done_load_i = 1'b1;
        tick();
        chk("co_c1_sld", 32'(start_load_o), 32'd1);
        tick();
        done_load_i = 1'b0;
        chk("co_c2_ack", 32'(ack_o), 32'd0);
        chk("co_c2_sel", 32'(ram_sel_o), 32'd2);
        tick();
        chk("co_c3_ack", 32'(ack_o), 32'd0);
        chk("co_c3_busy", 32'(busy_o), 32'd1);
        rst = 1'b1;
        #1;
        chk_all_zero("rstmid");
        switch_req_i = 1'b0;
        tick();
        rst = 1'b0;
        done_load_i = 1'b1;
        tick();
        done_load_i = 1'b0;
        chk("postrst_ack", 32'(ack_o), 32'd0);
        chk("postrst_res", 32'(resident_valid_o), 32'd0);
        chk("postrst_busy", 32'(busy_o), 32'd0);
        tick();
        chk("postrst_ack2", 32'(ack_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
